// File: rtl/rot_stream_buf.sv
// Purpose: valid/ready buffered front-end for a circular rotate datapath (DEPTH-entry FIFO + registered result).
// Latency: 2 edges from acceptance into an empty buffer to out_valid; 1 result/cycle sustained.
// Backpressure: in_ready drops only when the FIFO holds DEPTH entries; a stalled output holds its result and stops popping.
// Optional feature: define ROT_DIR_EN to add per-request rotate direction (in_dir/out_dir, 0=left, 1=right).
module rot_stream_buf #(
    parameter int DW    = 8,
    parameter int SW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_data,
    input  logic [SW-1:0]              in_amt,
`ifdef ROT_DIR_EN
    input  logic                       in_dir,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [SW-1:0]              out_amt,
`ifdef ROT_DIR_EN
    output logic                       out_dir,
`endif
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // One buffered request; the direction bit only exists when the feature is built in.
    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] amt;
`ifdef ROT_DIR_EN
        logic          dir;
`endif
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    entry_t          wr_entry;
    entry_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            load;
    logic [SW-1:0]   head_eff_amt;
    logic            head_right;
    logic [DW-1:0]   head_rot;

    // Reduce a rotate amount into 0..DW-1; DW need not be a power of two.
    function automatic logic [SW-1:0] mod_dw(input logic [SW-1:0] a);
        int v;
        v = int'(a) % DW;
        return SW'(v);
    endfunction

    // Circular rotate of x by k (< DW) via a doubled word, so any DW works.
    function automatic logic [DW-1:0] rotate(input logic [DW-1:0] x,
                                              input logic [SW-1:0] k,
                                              input logic          right);
        logic [2*DW-1:0] dd;
        logic [DW-1:0]   y;
        dd = {x, x};
        if (right) begin
            dd = dd >> k;
            y  = dd[DW-1:0];
        end else begin
            dd = dd << k;
            y  = dd[2*DW-1:DW];
        end
        return y;
    endfunction

    // Occupancy-derived flags; no write-through when full, even if a pop coincides.
    assign fifo_full  = (level == LW'(DEPTH));
    assign fifo_empty = (level == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign load       = !fifo_empty && (!out_valid || out_ready);

    // Pack the incoming request for storage.
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = in_data;
        wr_entry.amt  = in_amt;
`ifdef ROT_DIR_EN
        wr_entry.dir  = in_dir;
`endif
    end

    // Compute the result for the FIFO head so the output register can load it directly.
    always_comb begin
        head         = mem[rd_ptr];
        head_eff_amt = mod_dw(head.amt);
`ifdef ROT_DIR_EN
        head_right   = head.dir;
`else
        head_right   = 1'b0;
`endif
        head_rot     = rotate(head.data, head_eff_amt, head_right);
    end

    // FIFO storage: write the accepted request at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally; level tracks push/pop and is unchanged when both happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Output register: load from the head when free or being consumed, otherwise hold or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
`ifdef ROT_DIR_EN
            out_dir   <= 1'b0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= head_rot;
            out_amt   <= head_eff_amt;
`ifdef ROT_DIR_EN
            out_dir   <= head_right;
`endif
        end else if (out_valid && out_ready) begin
            // Consumed with nothing behind it: data stays, only valid falls.
            out_valid <= 1'b0;
        end
    end

endmodule
